task_arbiter: RTL and testbench

TASK_ARBITER -- requirements
Module: task_arbiter

---
 rtl/task_arbiter.sv | 164 ++++++++++++++++
 tb/tb_task_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_arbiter.sv
// ============================================================================
// task_arbiter : round-robin task arbiter between requesters and a scheduler,
//                routing completions back by tag. Option: TASK_ARBITER_PRIO_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module task_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int MAX_OUT = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_task,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [DATA_W-1:0]         sched_task,
   output logic                      sched_valid,
   input  logic                      sched_full,
   input  logic                      sched_done,
   input  logic [DATA_W-1:0]         sched_completed,
   output logic [NUM_REQ-1:0]        resp_done,
   output logic [DATA_W-1:0]         resp_task,
   output logic [$clog2(MAX_OUT):0]  outstanding,
   output logic                      err
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int PTR_W = $clog2(MAX_OUT);
   localparam int OUT_W = PTR_W + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   logic [0:0]         r_state;
   logic [IDX_W-1:0]   r_ptr;
   logic [IDX_W-1:0]   r_win;
   logic [NUM_REQ-1:0] r_full;
   logic [NUM_REQ-1:0] r_ready;
   logic [NUM_REQ-1:0] r_resp_done;
   logic [DATA_W-1:0]  r_hold [NUM_REQ];
   logic [DATA_W-1:0]  r_sched_task;
   logic [DATA_W-1:0]  r_resp_task;
   logic [IDX_W-1:0]   r_tag [MAX_OUT];
   logic [PTR_W-1:0]   r_wr;
   logic [PTR_W-1:0]   r_rd;
   logic [OUT_W-1:0]   r_out;
   logic               r_err;

   logic [NUM_REQ-1:0] w_cand;
   logic [NUM_REQ-1:0] w_take;
   logic [NUM_REQ-1:0] w_clr;
   logic [NUM_REQ-1:0] w_full_nxt;
   logic [IDX_W-1:0]   w_win;
   logic [IDX_W-1:0]   w_ptr_nxt;
   logic               w_found;
   logic               w_upd_ptr;
   logic               w_can_issue;
   logic               w_issue;
   logic               w_pop;
   int                 w_j;

   // Round-robin search starting at r_ptr; with priority enabled requester 0
   // is taken out of the rotation and overrides it whenever it holds a task.
   always_comb begin
      w_cand    = r_full;
      w_upd_ptr = 1'b1;
`ifdef TASK_ARBITER_PRIO_EN
      w_cand[0] = 1'b0;
`endif
      w_found = 1'b0;
      w_win   = '0;
      w_j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_j = int'(r_ptr) + k;
         if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
         if (!w_found && w_cand[w_j[IDX_W-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_j[IDX_W-1:0];
         end
      end
`ifdef TASK_ARBITER_PRIO_EN
      if (r_full[0]) begin
         w_win     = '0;
         w_upd_ptr = 1'b0;
      end
`endif
      w_ptr_nxt = (w_win == IDX_W'(NUM_REQ-1)) ? '0 : w_win + 1'b1;
   end

   assign w_can_issue = (r_state == S_IDLE) && (|r_full) && !sched_full &&
                        (r_out < OUT_W'(MAX_OUT));
   assign w_issue     = (r_state == S_ISSUE);
   assign w_pop       = sched_done && (r_out != '0);
   assign w_take      = req_valid & r_ready;
   // The winner's word moves into r_sched_task, so its slot frees on entry to ISSUE.
   assign w_clr       = {NUM_REQ{w_can_issue}} & (NUM_REQ'(1) << w_win);
   assign w_full_nxt  = (r_full & ~w_clr) | w_take;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_win        <= '0;
         r_full       <= '0;
         r_ready      <= '0;
         r_sched_task <= '0;
         r_wr         <= '0;
         r_rd         <= '0;
         r_out        <= '0;
         r_resp_done  <= '0;
         r_resp_task  <= '0;
         r_err        <= 1'b0;
      end else begin
         r_full      <= w_full_nxt;
         r_ready     <= ~w_full_nxt;
         r_resp_done <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_can_issue) begin
                  r_state      <= S_ISSUE;
                  r_win        <= w_win;
                  r_sched_task <= r_hold[w_win];
                  if (w_upd_ptr) r_ptr <= w_ptr_nxt;
               end
            end
            S_ISSUE: begin
               r_state      <= S_IDLE;
               r_sched_task <= '0;
               r_wr         <= r_wr + 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
         if (w_pop) begin
            r_rd        <= r_rd + 1'b1;
            r_resp_done <= NUM_REQ'(1) << r_tag[r_rd];
            r_resp_task <= sched_completed;
         end
         if (sched_done && (r_out == '0)) r_err <= 1'b1;
         if (w_issue && !w_pop)      r_out <= r_out + 1'b1;
         else if (!w_issue && w_pop) r_out <= r_out - 1'b1;
      end
   end

   // Payload storage only; validity lives in r_full and the FIFO pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_take[i]) r_hold[i] <= req_task[i*DATA_W +: DATA_W];
      end
      if (w_issue) r_tag[r_wr] <= r_win;
   end

   assign req_ready   = r_ready;
   assign sched_task  = r_sched_task;
   assign sched_valid = w_issue;
   assign resp_done   = r_resp_done;
   assign resp_task   = r_resp_task;
   assign outstanding = r_out;
   assign err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_task_arbiter.sv
// tb_task_arbiter : directed self-checking bench for task_arbiter (default
// parameters); the priority scenario follows TASK_ARBITER_PRIO_EN.
`timescale 1ns/1ps
`default_nettype none

module tb_task_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_task = '0;
   logic [3:0]  req_ready;
   logic [7:0]  sched_task;
   logic        sched_valid;
   logic        sched_full = 1'b0;
   logic        sched_done = 1'b0;
   logic [7:0]  sched_completed = '0;
   logic [3:0]  resp_done;
   logic [7:0]  resp_task;
   logic [3:0]  outstanding;
   logic        err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [7:0] issue_q[$];
   int         issue_t[$];
   logic [7:0] resp_q[$];

   task_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_OUT(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_task(req_task), .req_ready(req_ready),
      .sched_task(sched_task), .sched_valid(sched_valid),
      .sched_full(sched_full), .sched_done(sched_done),
      .sched_completed(sched_completed),
      .resp_done(resp_done), .resp_task(resp_task),
      .outstanding(outstanding), .err(err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (sched_valid) begin
            issue_q.push_back(sched_task);
            issue_t.push_back(cyc);
         end
         if (|resp_done) resp_q.push_back(resp_task);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at cyc=%0d want finish", cyc);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      req_valid = '0;
      req_task = '0;
      sched_full = 1'b0;
      sched_done = 1'b0;
      sched_completed = '0;
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      issue_q.delete();
      issue_t.delete();
      resp_q.delete();
   endtask

   task automatic offer(input int idx, input logic [7:0] data);
      int n;
      req_valid[idx] = 1'b1;
      req_task[idx*8 +: 8] = data;
      n = 0;
      while (req_ready[idx] !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) begin
         checks++; errors++;
         $display("FAIL offer_timeout req%0d ready=%b want 1", idx, req_ready[idx]);
      end
      tick();
      req_valid[idx] = 1'b0;
   endtask

   task automatic pulse_done(input logic [7:0] data);
      sched_done = 1'b1;
      sched_completed = data;
      tick();
      sched_done = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      checks++;
      if (req_ready !== 4'h0) begin
         errors++; $display("FAIL reset_req_ready got %h want 0", req_ready);
      end
      checks++;
      if (sched_valid !== 1'b0 || sched_task !== 8'h00) begin
         errors++; $display("FAIL reset_sched got v=%b t=%h want 0/00", sched_valid, sched_task);
      end
      checks++;
      if (resp_done !== 4'h0 || resp_task !== 8'h00) begin
         errors++; $display("FAIL reset_resp got d=%h t=%h want 0/00", resp_done, resp_task);
      end
      checks++;
      if (outstanding !== 4'd0 || err !== 1'b0) begin
         errors++; $display("FAIL reset_count got o=%0d e=%b want 0/0", outstanding, err);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (req_ready !== 4'hF) begin
         errors++; $display("FAIL reset_release_ready got %h want f", req_ready);
      end
   endtask

   task automatic test_single();
      logic [7:0] got;
      reset_dut();
      for (int n = 1; n <= 5; n++) offer(0, 8'(n));
      repeat (6) tick();
      checks++;
      if (issue_q.size() != 5) begin
         errors++; $display("FAIL single_issue_count got %0d want 5", issue_q.size());
      end
      for (int n = 1; n <= 5; n++) begin
         got = (n <= issue_q.size()) ? issue_q[n-1] : 8'hxx;
         checks++;
         if (got !== 8'(n)) begin
            errors++; $display("FAIL single_issue_%0d got %h want %h", n, got, 8'(n));
         end
      end
      checks++;
      if (outstanding !== 4'd5) begin
         errors++; $display("FAIL single_outstanding got %0d want 5", outstanding);
      end
      for (int n = 1; n <= 5; n++) begin
         pulse_done(8'(n));
         checks++;
         if (resp_done !== 4'b0001 || resp_task !== 8'(n)) begin
            errors++;
            $display("FAIL single_resp_%0d got d=%b t=%h want 0001/%h", n, resp_done, resp_task, 8'(n));
         end
      end
      tick();
      checks++;
      if (resp_done !== 4'b0000 || outstanding !== 4'd0) begin
         errors++; $display("FAIL single_drain got d=%b o=%0d want 0000/0", resp_done, outstanding);
      end
   endtask

   task automatic test_fairness();
      logic [7:0] exp_t [4];
      logic [7:0] got;
      exp_t = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
      reset_dut();
      req_task  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
      req_valid = 4'hF;
      tick();
      req_valid = '0;
      repeat (10) tick();
      checks++;
      if (issue_q.size() != 4) begin
         errors++; $display("FAIL fair_issue_count got %0d want 4", issue_q.size());
      end
      for (int k = 0; k < 4; k++) begin
         got = (k < issue_q.size()) ? issue_q[k] : 8'hxx;
         checks++;
         if (got !== exp_t[k]) begin
            errors++; $display("FAIL fair_order_%0d got %h want %h", k, got, exp_t[k]);
         end
      end
      // back-to-back offers: exactly one idle cycle between strobes
      for (int k = 1; k < 4; k++) begin
         if (k < issue_t.size()) begin
            checks++;
            if (issue_t[k] - issue_t[k-1] != 2) begin
               errors++;
               $display("FAIL back_to_back_gap_%0d got %0d want 2", k, issue_t[k] - issue_t[k-1]);
            end
         end
      end
      checks++;
      if (outstanding !== 4'd4) begin
         errors++; $display("FAIL fair_outstanding got %0d want 4", outstanding);
      end
      req_task  = {8'h53, 8'h00, 8'h51, 8'h00};
      req_valid = 4'b1010;
      tick();
      req_valid = '0;
      repeat (6) tick();
      got = (issue_q.size() > 4) ? issue_q[4] : 8'hxx;
      checks++;
      if (got !== 8'h51) begin
         errors++; $display("FAIL fair_ptr_wrap first got %h want 51", got);
      end
      got = (issue_q.size() > 5) ? issue_q[5] : 8'hxx;
      checks++;
      if (got !== 8'h53) begin
         errors++; $display("FAIL fair_ptr_wrap second got %h want 53", got);
      end
   endtask

   task automatic test_backpressure();
      int bad;
      reset_dut();
      sched_full = 1'b1;
      req_task   = {16'h0000, 8'h22, 8'h11};
      req_valid  = 4'b0011;
      tick();
      req_valid = '0;
      bad = 0;
      repeat (10) begin
         tick();
         if (sched_valid !== 1'b0 || req_ready[1:0] !== 2'b00) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL bp_hold got %0d bad cycles want 0", bad);
      end
      checks++;
      if (issue_q.size() != 0) begin
         errors++; $display("FAIL bp_no_issue got %0d issues want 0", issue_q.size());
      end
      sched_full = 1'b0;
      tick();
      checks++;
      if (sched_valid !== 1'b1 || sched_task !== 8'h11) begin
         errors++; $display("FAIL bp_resume got v=%b t=%h want 1/11", sched_valid, sched_task);
      end
      tick();
      checks++;
      if (sched_valid !== 1'b0) begin
         errors++; $display("FAIL bp_gap got v=%b want 0", sched_valid);
      end
      tick();
      checks++;
      if (sched_valid !== 1'b1 || sched_task !== 8'h22) begin
         errors++; $display("FAIL bp_second got v=%b t=%h want 1/22", sched_valid, sched_task);
      end
   endtask

   task automatic test_limit();
      logic [7:0] got;
      reset_dut();
      for (int n = 0; n < 9; n++) offer(n % 4, 8'(8'h30 + n));
      repeat (10) tick();
      checks++;
      if (issue_q.size() != 8) begin
         errors++; $display("FAIL limit_issue_count got %0d want 8", issue_q.size());
      end
      got = (issue_q.size() > 7) ? issue_q[7] : 8'hxx;
      checks++;
      if (got !== 8'h37) begin
         errors++; $display("FAIL limit_eighth got %h want 37", got);
      end
      checks++;
      if (outstanding !== 4'd8 || sched_valid !== 1'b0 || req_ready[0] !== 1'b0) begin
         errors++;
         $display("FAIL limit_full got o=%0d v=%b r0=%b want 8/0/0", outstanding, sched_valid, req_ready[0]);
      end
      pulse_done(8'hE1);
      checks++;
      if (outstanding !== 4'd7 || resp_done !== 4'b0001 || resp_task !== 8'hE1) begin
         errors++;
         $display("FAIL limit_done got o=%0d d=%b t=%h want 7/0001/e1", outstanding, resp_done, resp_task);
      end
      tick();
      checks++;
      if (sched_valid !== 1'b1 || sched_task !== 8'h38) begin
         errors++; $display("FAIL limit_ninth got v=%b t=%h want 1/38", sched_valid, sched_task);
      end
      sched_done = 1'b1;
      sched_completed = 8'hE2;
      tick();
      sched_done = 1'b0;
      checks++;
      if (outstanding !== 4'd7 || resp_done !== 4'b0010) begin
         errors++; $display("FAIL limit_issue_and_done got o=%0d d=%b want 7/0010", outstanding, resp_done);
      end
   endtask

   task automatic test_error_reset();
      int rc;
      reset_dut();
      pulse_done(8'h77);
      checks++;
      if (err !== 1'b1 || resp_done !== 4'b0000 || outstanding !== 4'd0) begin
         errors++;
         $display("FAIL err_set got e=%b d=%b o=%0d want 1/0000/0", err, resp_done, outstanding);
      end
      repeat (3) tick();
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL err_sticky got %b want 1", err);
      end
      offer(0, 8'h61);
      offer(1, 8'h62);
      offer(2, 8'h63);
      repeat (8) tick();
      checks++;
      if (outstanding !== 4'd3) begin
         errors++; $display("FAIL err_pre_reset_outstanding got %0d want 3", outstanding);
      end
      rc = resp_q.size();
      rst_n = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd0 || err !== 1'b0 || req_ready !== 4'h0) begin
         errors++;
         $display("FAIL async_reset got o=%0d e=%b r=%h want 0/0/0", outstanding, err, req_ready);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      repeat (5) tick();
      checks++;
      if (resp_q.size() != rc || outstanding !== 4'd0 || err !== 1'b0) begin
         errors++;
         $display("FAIL post_reset got resp=%0d o=%0d e=%b want %0d/0/0", resp_q.size(), outstanding, err, rc);
      end
   endtask

   task automatic test_priority();
      logic [7:0] exp_t [6];
      logic [7:0] got;
`ifdef TASK_ARBITER_PRIO_EN
      exp_t = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
`else
      exp_t = '{8'h10, 8'h20, 8'h10, 8'h20, 8'h10, 8'h20};
`endif
      reset_dut();
      req_task  = {8'h00, 8'h20, 8'h00, 8'h10};
      req_valid = 4'b0101;
      repeat (14) tick();
      req_valid = '0;
      for (int k = 0; k < 6; k++) begin
         got = (k < issue_q.size()) ? issue_q[k] : 8'hxx;
         checks++;
         if (got !== exp_t[k]) begin
            errors++; $display("FAIL prio_slot_%0d got %h want %h", k, got, exp_t[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_backpressure();
      test_limit();
      test_error_reset();
      test_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
